truth_table_checker: RTL and testbench

Synthesizable stimulus/response engine for small combinational gates (e.g. CMOS-level AND3/OR3 netlists) on the FPGA.
- Sweeps every input vector 0..2^N_IN-1 onto the DUT.
- Waits a programmable settle time, then samples the DUT output.
- Compares each sample against a parameterized truth table and reports the mismatch count, the first failing vector, and pass/fail.
- Also emits a per-vector result strobe so a UART/LED logger can print the table.

---
 rtl/truth_table_checker_pkg.sv | 17 +
 rtl/truth_table_checker_if.sv | 33 +++
 rtl/truth_table_checker_settle_timer.sv | 28 ++
 rtl/truth_table_checker.sv | 133 +++++++++++++
 tb/tb_truth_table_checker.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table sweep engine.
// States, vector-count helper and settle-timer width.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int SETTLE_W = 4;

    function automatic int n_vec(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bundle between the sweep engine and its gate under test / logger.
// master = checker side, slave = stimulus/observer side.
interface truth_table_checker_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic [N_IN-1:0] x_out;
    logic            y_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic            first_err_valid;
    logic [N_IN-1:0] first_err_idx;
    logic            result_wr;
    logic [N_IN-1:0] result_idx;
    logic            result_y;
    logic            result_ok;

    modport master (
        input  start, y_in,
        output x_out, busy, done, pass, err_cnt,
        output first_err_valid, first_err_idx,
        output result_wr, result_idx, result_y, result_ok
    );

    modport slave (
        output start, y_in,
        input  x_out, busy, done, pass, err_cnt,
        input  first_err_valid, first_err_idx,
        input  result_wr, result_idx, result_y, result_ok
    );
endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter timing the DRIVE phase of each vector.
// o_zero is high once the count has run out.
module tt_settle_timer
    import tt_check_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_val,
    input  logic                i_en,
    output logic                o_zero
);

    logic [SETTLE_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors onto a small combinational gate, samples
// its output after a settle time and scores it against TRUTH.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                      N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = 8'b1000_0000,
    parameter int                      SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_checker_if.master bus
);

    localparam int              N_VEC   = n_vec(N_IN);
    localparam logic [N_IN-1:0] IDX_MAX = N_IN'(N_VEC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD =
        SETTLE_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
    // With no settle time the DRIVE phase collapses to zero cycles
    localparam state_t ENTRY = (SETTLE == 0) ? SAMPLE : DRIVE;

    state_t          r_state;
    logic [N_IN-1:0] r_idx;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_err_cnt;
    logic            r_fe_valid;
    logic [N_IN-1:0] r_fe_idx;
    logic            r_res_wr;
    logic [N_IN-1:0] r_res_idx;
    logic            r_res_y;
    logic            r_res_ok;

    logic w_last;
    logic w_mis;
    logic w_tmr_load;
    logic w_tmr_en;
    logic w_tmr_zero;

    assign w_last = (r_idx == IDX_MAX);
    assign w_mis  = (bus.y_in != TRUTH[r_idx]);

    assign w_tmr_load = ((r_state == IDLE) && bus.start) ||
                        ((r_state == SAMPLE) && !w_last);
    assign w_tmr_en   = (r_state == DRIVE);

    tt_settle_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_val  (SETTLE_LD),
        .i_en   (w_tmr_en),
        .o_zero (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fe_valid <= 1'b0;
            r_fe_idx   <= '0;
            r_res_wr   <= 1'b0;
            r_res_idx  <= '0;
            r_res_y    <= 1'b0;
            r_res_ok   <= 1'b0;
        end else begin
            r_res_wr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= ENTRY;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err_cnt  <= '0;
                        r_fe_valid <= 1'b0;
                        r_fe_idx   <= '0;
                    end
                end
                DRIVE: begin
                    if (w_tmr_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_res_wr  <= 1'b1;
                    r_res_idx <= r_idx;
                    r_res_y   <= bus.y_in;
                    r_res_ok  <= !w_mis;
                    if (w_mis) begin
                        r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
                        if (!r_fe_valid) begin
                            r_fe_valid <= 1'b1;
                            r_fe_idx   <= r_idx;
                        end
                    end
                    // x_out keeps the last vector once the sweep ends
                    if (w_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_cnt == '0) && !w_mis;
                    end else begin
                        r_state <= ENTRY;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.x_out           = r_idx;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_cnt         = r_err_cnt;
    assign bus.first_err_valid = r_fe_valid;
    assign bus.first_err_idx   = r_fe_idx;
    assign bus.result_wr       = r_res_wr;
    assign bus.result_idx      = r_res_idx;
    assign bus.result_y        = r_res_y;
    assign bus.result_ok       = r_res_ok;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: sweeps push expected results, a monitor pops them
// on every result strobe; sweep-level status is checked per task.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst;
    int   mode_a;
    int   mode_b;

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(3)) ifa ();
    truth_table_checker_if #(.N_IN(3)) ifb ();

    // mode 0: correct AND3, 1: stuck-at-0, 2: stuck-at-1
    assign ifa.y_in = (mode_a == 0) ? (&ifa.x_out) :
                      (mode_a == 1) ? 1'b0 : 1'b1;
    assign ifb.y_in = (mode_b == 1);

    truth_table_checker #(
        .N_IN(3), .TRUTH(8'b1000_0000), .SETTLE(2)
    ) u_a (
        .clk(clk), .rst(rst), .bus(ifa.master)
    );

    truth_table_checker #(
        .N_IN(3), .TRUTH(8'b0000_0000), .SETTLE(0)
    ) u_b (
        .clk(clk), .rst(rst), .bus(ifb.master)
    );

    typedef struct {
        int idx;
        int y;
        int ok;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    res_t ea;
    res_t eb;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.result_wr) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result_wr", int'(ifa.result_idx), -1);
            end else begin
                ea = qa.pop_front();
                chk("a_result_idx", int'(ifa.result_idx), ea.idx);
                chk("a_result_y", int'(ifa.result_y), ea.y);
                chk("a_result_ok", int'(ifa.result_ok), ea.ok);
            end
        end
        if (ifb.result_wr) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result_wr", int'(ifb.result_idx), -1);
            end else begin
                eb = qb.pop_front();
                chk("b_result_idx", int'(ifb.result_idx), eb.idx);
                chk("b_result_y", int'(ifb.result_y), eb.y);
                chk("b_result_ok", int'(ifb.result_ok), eb.ok);
            end
        end
    end

    // AND3 truth table: only vector 7 yields 1
    task automatic push_a(input int mode, input int n);
        res_t r;
        for (int k = 0; k < n; k++) begin
            r.idx = k;
            r.y   = (mode == 0) ? int'(k == 7) : (mode == 1) ? 0 : 1;
            r.ok  = int'(r.y == int'(k == 7));
            qa.push_back(r);
        end
    endtask

    task automatic push_b(input int mode);
        res_t r;
        for (int k = 0; k < 8; k++) begin
            r.idx = k;
            r.y   = mode;
            r.ok  = int'(mode == 0);
            qb.push_back(r);
        end
    endtask

    task automatic sweep_a(input int mode, input int e_err,
                           input int e_fv, input int e_fi,
                           input int mid_k);
        int k;
        int wrs;
        mode_a = mode;
        push_a(mode, 8);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        chk("a_busy_p1", int'(ifa.busy), 1);
        chk("a_done_p1", int'(ifa.done), 0);
        k   = 1;
        wrs = 0;
        while (1) begin
            if (ifa.result_wr) wrs++;
            if (ifa.done || k >= 200) break;
            ifa.start = (k == mid_k);
            @(negedge clk);
            k++;
        end
        ifa.start = 1'b0;
        chk("a_done_cycle", k, 25);
        chk("a_wr_count", wrs, 8);
        chk("a_busy_end", int'(ifa.busy), 0);
        chk("a_err_cnt", int'(ifa.err_cnt), e_err);
        chk("a_pass", int'(ifa.pass), int'(e_err == 0));
        chk("a_first_err_valid", int'(ifa.first_err_valid), e_fv);
        chk("a_first_err_idx", int'(ifa.first_err_idx), e_fi);
        @(negedge clk);
        chk("a_done_sticky", int'(ifa.done), 1);
        chk("a_x_out_held", int'(ifa.x_out), 7);
        chk("a_queue_empty", qa.size(), 0);
    endtask

    task automatic sweep_b(input int mode, input int e_err,
                           input int e_fv, input int e_fi);
        int k;
        int wrs;
        mode_b = mode;
        push_b(mode);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        k   = 1;
        wrs = 0;
        while (1) begin
            if (ifb.result_wr) wrs++;
            if (ifb.done || k >= 100) break;
            @(negedge clk);
            k++;
        end
        chk("b_done_cycle", k, 9);
        chk("b_wr_count", wrs, 8);
        chk("b_err_cnt", int'(ifb.err_cnt), e_err);
        chk("b_pass", int'(ifb.pass), int'(e_err == 0));
        chk("b_first_err_valid", int'(ifb.first_err_valid), e_fv);
        chk("b_first_err_idx", int'(ifb.first_err_idx), e_fi);
        @(negedge clk);
        chk("b_queue_empty", qb.size(), 0);
    endtask

    task automatic reset_mid_sweep();
        int k;
        mode_a = 2;
        push_a(2, 4);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (k = 1; k < 13; k++) @(negedge clk);
        chk("a_x_out_pre_rst", int'(ifa.x_out), 4);
        chk("a_err_pre_rst", int'(ifa.err_cnt), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("a_busy_post_rst", int'(ifa.busy), 0);
        chk("a_done_post_rst", int'(ifa.done), 0);
        chk("a_err_post_rst", int'(ifa.err_cnt), 0);
        chk("a_x_out_post_rst", int'(ifa.x_out), 0);
        repeat (30) @(negedge clk);
        chk("a_idle_after_rst", int'(ifa.busy), 0);
        chk("a_queue_after_rst", qa.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        mode_a    = 0;
        mode_b    = 0;
        repeat (3) @(negedge clk);
        chk("rst_x_out", int'(ifa.x_out), 0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_done", int'(ifa.done), 0);
        chk("rst_pass", int'(ifa.pass), 0);
        chk("rst_err_cnt", int'(ifa.err_cnt), 0);
        chk("rst_fe_valid", int'(ifa.first_err_valid), 0);
        chk("rst_result_wr", int'(ifa.result_wr), 0);
        rst = 1'b0;
        @(negedge clk);

        sweep_a(0, 0, 0, 0, -1);
        sweep_a(0, 0, 0, 0, -1);
        sweep_a(1, 1, 1, 7, -1);
        sweep_a(2, 7, 1, 0, -1);
        reset_mid_sweep();
        sweep_a(0, 0, 0, 0, 10);
        sweep_b(1, 8, 1, 0);
        sweep_b(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
